id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline register of the pipelined MIPS core. Sits directly downstream of the main decoder.
- Captures the decoder's control bits, register-file operands, immediate, PC+4 and register specifiers into the EX stage.
- Contains the load-use hazard detector: it inserts bubbles and generates stall requests for the fetch and decode stages.
- Applies branch/jump flushes and an external freeze, and counts load-use bubbles for performance monitoring.

Parameters:
W, 32, datapath width for operands, immediate and PC+4
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous reset, active-high
hold_i  in  1  external freeze (memory wait); register retains contents
flush_i  in  1  kill the instruction entering EX (taken branch/jump)
valid_d_i  in  1  decode-stage instruction is valid
ctrl_d_i  in  10  packed {Branch_eq, Branch_ne, MemToReg, ALUSrc, RegDest, RegWrite, MemWrite, JAL, ALUOp[1:0]}, bit 9 = Branch_eq
rd1_d_i  in  W  register-file read data 1
rd2_d_i  in  W  register-file read data 2
imm_d_i  in  W  sign-extended immediate
pcplus4_d_i  in  W  PC+4 of the decode instruction
rs_d_i  in  5  rs specifier
rt_d_i  in  5  rt specifier
rd_d_i  in  5  rd specifier
valid_e_o  out  1  EX-stage instruction valid
ctrl_e_o  out  10  registered control, same packing as ctrl_d_i
rd1_e_o  out  W  registered rd1
rd2_e_o  out  W  registered rd2
imm_e_o  out  W  registered immediate
pcplus4_e_o  out  W  registered PC+4
rs_e_o  out  5  registered rs
rt_e_o  out  5  registered rt
rd_e_o  out  5  registered rd
stall_f_o  out  1  fetch stage must hold PC
stall_d_o  out  1  IF/ID register must hold
bubble_cnt_o  out  CNT_W  load-use bubbles inserted since reset

Behaviour:
- Reset (synchronous, evaluated at clk edge): all registered outputs go to 0, including valid_e_o, ctrl_e_o, all data/specifier fields and bubble_cnt_o. Reset overrides hold_i and flush_i.
- load_use (combinational) is true when all of the following hold:
  - valid_e_o = 1
  - ctrl_e_o.MemToReg = 1 and ctrl_e_o.RegWrite = 1
  - rt_e_o != 0
  - valid_d_i = 1
  - rt_e_o == rs_d_i or rt_e_o == rt_d_i
- stall_f_o = stall_d_o = load_use & ~flush_i. These are purely combinational, with zero latency, and are not gated by hold_i.
- Update priority at each rising edge when reset = 0:
  1. hold_i = 1: every register, including the counter, retains its value. flush_i and load_use are ignored. Upstream keeps flush_i asserted until hold_i drops.
  2. flush_i = 1: load a bubble (valid_e_o = 0, ctrl_e_o = 0, all data/specifier fields = 0). The counter is not incremented.
  3. load_use = 1: load a bubble as in 2 and increment bubble_cnt_o.
  4. Otherwise: load all D inputs, valid_e_o = valid_d_i, and ctrl_e_o = valid_d_i ? ctrl_d_i : 0. An invalid instruction never carries live RegWrite or MemWrite.
- Latency: one cycle, D inputs to E outputs.
- A load-use stall lasts exactly one cycle. After the bubble, valid_e_o = 0, so load_use deasserts and the held instruction advances on the next edge.
- bubble_cnt_o saturates at 2^CNT_W - 1 and never wraps.
- Flush and load_use together: flush wins, no stall is issued and the counter is unchanged.
- A register-0 destination never creates a hazard.
- JAL passes through with RegWrite = 1 and MemToReg = 0, so it never triggers a stall.

Decomposition:
- Shared package core_pkg holds:
  - CTRL_W = 10
  - bit-index constants CTRL_BEQ = 9, CTRL_BNE = 8, CTRL_MEMTOREG = 7, CTRL_ALUSRC = 6, CTRL_REGDEST = 5, CTRL_REGWRITE = 4, CTRL_MEMWRITE = 3, CTRL_JAL = 2, CTRL_ALUOP = 1:0
  - the ALUOp encodings 00 (add), 01 (sub/compare), 10 (funct)
- One sub-module, hazard_detect: purely combinational. Takes the E-stage load info and the D-stage specifiers; produces load_use.
- Registers and the counter stay in id_ex_pipe.

Test Plan:
- Basic pass:
  - Stimulus: reset for 2 cycles, then valid ADD (ctrl 10'b0000110010, rs = 1, rt = 2, rd = 3, rd1 = 5, rd2 = 7).
  - Required: those exact values appear on E outputs one cycle later, with stalls = 0.
- Load-use:
  - Stimulus: LW with rt = 8 in EX, then D instruction with rs = 8.
  - Required: stall_f_o = stall_d_o = 1 for one cycle. Next cycle valid_e_o = 0, ctrl_e_o = 0 and bubble_cnt_o = 1. The following cycle the held instruction appears in EX.
- Zero register:
  - Stimulus: LW with rt = 0 in EX, D instruction with rs = 0.
  - Required: no stall, and the instruction is loaded normally.
- Flush priority:
  - Stimulus: load-use condition and flush_i = 1 in the same cycle.
  - Required: stalls = 0, bubble loaded, bubble_cnt_o unchanged.
- Hold:
  - Stimulus: hold_i = 1 for 3 cycles while D inputs change and flush_i = 1.
  - Required: E outputs and counter frozen. After hold_i drops with flush_i still 1, a bubble is loaded.
- Saturation and reset:
  - Stimulus: with CNT_W = 2, force 5 load-use bubbles, then assert reset mid-stream.
  - Required: counter reads 3 after the 3rd bubble and stays 3. Reset clears all outputs to 0 on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Holds the packed control-word layout produced by the main decoder,
// the ALUOp encodings, and a helper that recognises a load.
// No ports: this is a package imported with "import core_pkg::*".

package core_pkg;

   localparam int CTRL_W = 10;

   // Bit positions inside the packed control word.
   // Layout: {Branch_eq, Branch_ne, MemToReg, ALUSrc, RegDest, RegWrite, MemWrite, JAL, ALUOp[1:0]}
   localparam int CTRL_BEQ      = 9;
   localparam int CTRL_BNE      = 8;
   localparam int CTRL_MEMTOREG = 7;
   localparam int CTRL_ALUSRC   = 6;
   localparam int CTRL_REGDEST  = 5;
   localparam int CTRL_REGWRITE = 4;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_JAL      = 2;
   localparam int CTRL_ALUOP_HI = 1;
   localparam int CTRL_ALUOP_LO = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // A load is the only instruction whose result arrives from memory
   // and writes a register, which is what makes it a load-use producer.
   function automatic logic is_load(input ctrl_t c);
      return c[CTRL_MEMTOREG] & c[CTRL_REGWRITE];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   valid_e_i  - EX-stage instruction is valid
//   load_e_i   - EX-stage instruction is a load (MemToReg and RegWrite)
//   rt_e_i     - destination register of the EX-stage load
//   valid_d_i  - decode-stage instruction is valid
//   rs_d_i     - decode-stage rs specifier
//   rt_d_i     - decode-stage rt specifier
//   load_use_o - decode instruction needs data the EX load has not fetched yet

module hazard_detect (
   input  logic       valid_e_i,
   input  logic       load_e_i,
   input  logic [4:0] rt_e_i,
   input  logic       valid_d_i,
   input  logic [4:0] rs_d_i,
   input  logic [4:0] rt_d_i,
   output logic       load_use_o
);

   logic src_match;

   // Register 0 is hardwired to zero, so a load targeting it never
   // produces a value anyone can depend on.
   always_comb begin
      src_match  = (rt_e_i == rs_d_i) || (rt_e_i == rt_d_i);
      load_use_o = valid_e_i && load_e_i && (rt_e_i != 5'd0) && valid_d_i && src_match;
   end

endmodule

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with load-use stall generation.
// Ports:
//   clk, reset (synchronous, active-high)
//   hold_i     - external freeze, every register keeps its value
//   flush_i    - kill the instruction entering EX
//   *_d_i      - decode-stage instruction fields (valid, ctrl, operands, imm, PC+4, rs/rt/rd)
//   *_e_o      - registered EX-stage copies of the same fields
//   stall_f_o  - fetch must hold PC
//   stall_d_o  - IF/ID register must hold
//   bubble_cnt_o - saturating count of load-use bubbles since reset

module id_ex_pipe
   import core_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              valid_d_i,
   input  logic [CTRL_W-1:0] ctrl_d_i,
   input  logic [W-1:0]      rd1_d_i,
   input  logic [W-1:0]      rd2_d_i,
   input  logic [W-1:0]      imm_d_i,
   input  logic [W-1:0]      pcplus4_d_i,
   input  logic [4:0]        rs_d_i,
   input  logic [4:0]        rt_d_i,
   input  logic [4:0]        rd_d_i,
   output logic              valid_e_o,
   output logic [CTRL_W-1:0] ctrl_e_o,
   output logic [W-1:0]      rd1_e_o,
   output logic [W-1:0]      rd2_e_o,
   output logic [W-1:0]      imm_e_o,
   output logic [W-1:0]      pcplus4_e_o,
   output logic [4:0]        rs_e_o,
   output logic [4:0]        rt_e_o,
   output logic [4:0]        rd_e_o,
   output logic              stall_f_o,
   output logic              stall_d_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              valid_q,      valid_d;
   ctrl_t             ctrl_q,       ctrl_d;
   logic [W-1:0]      rd1_q,        rd1_d;
   logic [W-1:0]      rd2_q,        rd2_d;
   logic [W-1:0]      imm_q,        imm_d;
   logic [W-1:0]      pcplus4_q,    pcplus4_d;
   logic [4:0]        rs_q,         rs_d;
   logic [4:0]        rt_q,         rt_d;
   logic [4:0]        rd_q,         rd_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              load_use;

   hazard_detect u_hazard_detect (
      .valid_e_i  (valid_q),
      .load_e_i   (is_load(ctrl_q)),
      .rt_e_i     (rt_q),
      .valid_d_i  (valid_d_i),
      .rs_d_i     (rs_d_i),
      .rt_d_i     (rt_d_i),
      .load_use_o (load_use)
   );

   // A flush already discards the dependent instruction, so stalling for it
   // would only waste a cycle. Stalls ignore hold_i on purpose: upstream
   // combines them with its own freeze.
   assign stall_f_o = load_use & ~flush_i;
   assign stall_d_o = load_use & ~flush_i;

   // Next-state selection: hold > flush > load-use bubble > normal advance.
   // Bubbles clear every field so a killed instruction leaves no trace in EX.
   always_comb begin
      valid_d      = valid_q;
      ctrl_d       = ctrl_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      imm_d        = imm_q;
      pcplus4_d    = pcplus4_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      rd_d         = rd_q;
      bubble_cnt_d = bubble_cnt_q;

      if (!hold_i) begin
         if (flush_i || load_use) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            pcplus4_d = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            // Only genuine load-use bubbles are counted, and the counter
            // sticks at all-ones instead of wrapping.
            if (!flush_i && (bubble_cnt_q != {CNT_W{1'b1}})) begin
               bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
         end else begin
            valid_d   = valid_d_i;
            // An invalid slot must never carry live RegWrite/MemWrite.
            ctrl_d    = valid_d_i ? ctrl_d_i : '0;
            rd1_d     = rd1_d_i;
            rd2_d     = rd2_d_i;
            imm_d     = imm_d_i;
            pcplus4_d = pcplus4_d_i;
            rs_d      = rs_d_i;
            rt_d      = rt_d_i;
            rd_d      = rd_d_i;
         end
      end
   end

   // State register; reset wins over hold and flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= 1'b0;
         ctrl_q       <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         pcplus4_q    <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         ctrl_q       <= ctrl_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         pcplus4_q    <= pcplus4_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign valid_e_o    = valid_q;
   assign ctrl_e_o     = ctrl_q;
   assign rd1_e_o      = rd1_q;
   assign rd2_e_o      = rd2_q;
   assign imm_e_o      = imm_q;
   assign pcplus4_e_o  = pcplus4_q;
   assign rs_e_o       = rs_q;
   assign rt_e_o       = rt_q;
   assign rd_e_o       = rd_q;
   assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe.
// Two instances share one stimulus stream: the default 16-bit counter and a
// 2-bit counter that reaches saturation quickly. A reference model of the
// stage predicts every output and is compared on each falling edge; directed
// steps also check hand-computed literal values.

module tb_id_ex_pipe;

   typedef struct packed {
      logic        valid;
      logic [9:0]  ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } instr_t;

   localparam logic [9:0] C_ADD = 10'b0000110010;
   localparam logic [9:0] C_LW  = 10'b0011010000;
   localparam logic [9:0] C_JAL = 10'b0000010100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        hold_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_d_i = 1'b0;
   logic [9:0]  ctrl_d_i = '0;
   logic [31:0] rd1_d_i = '0, rd2_d_i = '0, imm_d_i = '0, pcplus4_d_i = '0;
   logic [4:0]  rs_d_i = '0, rt_d_i = '0, rd_d_i = '0;

   logic        valid_e_o, stall_f_o, stall_d_o;
   logic [9:0]  ctrl_e_o;
   logic [31:0] rd1_e_o, rd2_e_o, imm_e_o, pcplus4_e_o;
   logic [4:0]  rs_e_o, rt_e_o, rd_e_o;
   logic [15:0] bubble_cnt_o;

   logic        s_valid, s_stall_f, s_stall_d;
   logic [9:0]  s_ctrl;
   logic [31:0] s_rd1, s_rd2, s_imm, s_pc;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic [1:0]  s_cnt;

   int checks = 0;
   int errors = 0;

   instr_t m_ex;
   int     m_cnt16;
   int     m_cnt2;
   bit     compare_en = 1'b0;
   logic   last_stall_f, last_stall_d;

   always #5 clk = ~clk;

   id_ex_pipe #(.W(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
      .valid_d_i(valid_d_i), .ctrl_d_i(ctrl_d_i), .rd1_d_i(rd1_d_i), .rd2_d_i(rd2_d_i),
      .imm_d_i(imm_d_i), .pcplus4_d_i(pcplus4_d_i), .rs_d_i(rs_d_i), .rt_d_i(rt_d_i),
      .rd_d_i(rd_d_i), .valid_e_o(valid_e_o), .ctrl_e_o(ctrl_e_o), .rd1_e_o(rd1_e_o),
      .rd2_e_o(rd2_e_o), .imm_e_o(imm_e_o), .pcplus4_e_o(pcplus4_e_o), .rs_e_o(rs_e_o),
      .rt_e_o(rt_e_o), .rd_e_o(rd_e_o), .stall_f_o(stall_f_o), .stall_d_o(stall_d_o),
      .bubble_cnt_o(bubble_cnt_o)
   );

   id_ex_pipe #(.W(32), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
      .valid_d_i(valid_d_i), .ctrl_d_i(ctrl_d_i), .rd1_d_i(rd1_d_i), .rd2_d_i(rd2_d_i),
      .imm_d_i(imm_d_i), .pcplus4_d_i(pcplus4_d_i), .rs_d_i(rs_d_i), .rt_d_i(rt_d_i),
      .rd_d_i(rd_d_i), .valid_e_o(s_valid), .ctrl_e_o(s_ctrl), .rd1_e_o(s_rd1),
      .rd2_e_o(s_rd2), .imm_e_o(s_imm), .pcplus4_e_o(s_pc), .rs_e_o(s_rs),
      .rt_e_o(s_rt), .rd_e_o(s_rd), .stall_f_o(s_stall_f), .stall_d_o(s_stall_d),
      .bubble_cnt_o(s_cnt)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // The model's view of a hazard: EX holds a valid load writing a nonzero
   // register that the valid decode instruction reads.
   function automatic bit modelHazard();
      bit ex_is_load;
      ex_is_load = m_ex.valid && m_ex.ctrl[7] && m_ex.ctrl[4];
      return ex_is_load && (m_ex.rt != 5'd0) && valid_d_i &&
             ((m_ex.rt == rs_d_i) || (m_ex.rt == rt_d_i));
   endfunction

   // Reference model: advances once per rising edge from the inputs that
   // were stable at that edge.
   always @(posedge clk) begin
      bit hz;
      if (reset) begin
         m_ex    = '0;
         m_cnt16 = 0;
         m_cnt2  = 0;
         compare_en = 1'b1;
      end else if (!hold_i) begin
         hz = modelHazard();
         if (flush_i) begin
            m_ex = '0;
         end else if (hz) begin
            m_ex = '0;
            if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
            if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
         end else begin
            m_ex.valid = valid_d_i;
            m_ex.ctrl  = valid_d_i ? ctrl_d_i : 10'd0;
            m_ex.rd1   = rd1_d_i;
            m_ex.rd2   = rd2_d_i;
            m_ex.imm   = imm_d_i;
            m_ex.pc    = pcplus4_d_i;
            m_ex.rs    = rs_d_i;
            m_ex.rt    = rt_d_i;
            m_ex.rd    = rd_d_i;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      bit exp_stall;
      if (compare_en) begin
         exp_stall = modelHazard() && !flush_i;
         checkOutput("valid_e", valid_e_o, m_ex.valid);
         checkOutput("ctrl_e", ctrl_e_o, m_ex.ctrl);
         checkOutput("rd1_e", rd1_e_o, m_ex.rd1);
         checkOutput("rd2_e", rd2_e_o, m_ex.rd2);
         checkOutput("imm_e", imm_e_o, m_ex.imm);
         checkOutput("pcplus4_e", pcplus4_e_o, m_ex.pc);
         checkOutput("rs_e", rs_e_o, m_ex.rs);
         checkOutput("rt_e", rt_e_o, m_ex.rt);
         checkOutput("rd_e", rd_e_o, m_ex.rd);
         checkOutput("stall_f", stall_f_o, exp_stall);
         checkOutput("stall_d", stall_d_o, exp_stall);
         checkOutput("bubble_cnt", bubble_cnt_o, m_cnt16);
         checkOutput("sat_valid_e", s_valid, m_ex.valid);
         checkOutput("sat_stall_f", s_stall_f, exp_stall);
         checkOutput("sat_bubble_cnt", s_cnt, m_cnt2);
      end
   end

   // Drive one decode slot, sample the stall outputs before the capturing
   // edge, then return just after that edge.
   task automatic applyStimulus(input logic hold, input logic flush, input logic valid,
                                input logic [9:0] ctrl, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd);
      hold_i      = hold;
      flush_i     = flush;
      valid_d_i   = valid;
      ctrl_d_i    = ctrl;
      rd1_d_i     = rd1;
      rd2_d_i     = rd2;
      imm_d_i     = rd1 ^ 32'h0000_00ff;
      pcplus4_d_i = rd2 + 32'd4;
      rs_d_i      = rs;
      rt_d_i      = rt;
      rd_d_i      = rd;
      #2;
      last_stall_f = stall_f_o;
      last_stall_d = stall_d_o;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_valid", valid_e_o, 1'b0);
      checkOutput("reset_cnt", bubble_cnt_o, 16'd0);

      // Basic pass
      applyStimulus(0, 0, 1, C_ADD, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3);
      checkOutput("add_valid", valid_e_o, 1'b1);
      checkOutput("add_ctrl", ctrl_e_o, 10'b0000110010);
      checkOutput("add_rd1", rd1_e_o, 32'd5);
      checkOutput("add_rd2", rd2_e_o, 32'd7);
      checkOutput("add_rs_rt_rd", {rs_e_o, rt_e_o, rd_e_o}, {5'd1, 5'd2, 5'd3});
      checkOutput("add_stall", {last_stall_f, last_stall_d}, 2'b00);

      // Load-use: LW rt=8, then a reader of r8 stalls one cycle
      applyStimulus(0, 0, 1, C_LW, 32'd100, 32'd0, 5'd1, 5'd8, 5'd0);
      applyStimulus(0, 0, 1, C_ADD, 32'd21, 32'd22, 5'd8, 5'd9, 5'd10);
      checkOutput("lu_stall", {last_stall_f, last_stall_d}, 2'b11);
      checkOutput("lu_bubble_valid", valid_e_o, 1'b0);
      checkOutput("lu_bubble_ctrl", ctrl_e_o, 10'd0);
      checkOutput("lu_cnt", bubble_cnt_o, 16'd1);
      applyStimulus(0, 0, 1, C_ADD, 32'd21, 32'd22, 5'd8, 5'd9, 5'd10);
      checkOutput("lu_release_stall", last_stall_f, 1'b0);
      checkOutput("lu_release_rs", rs_e_o, 5'd8);
      checkOutput("lu_release_rd1", rd1_e_o, 32'd21);

      // Zero register never hazards
      applyStimulus(0, 0, 1, C_LW, 32'd1, 32'd0, 5'd2, 5'd0, 5'd0);
      applyStimulus(0, 0, 1, C_ADD, 32'd33, 32'd34, 5'd0, 5'd0, 5'd4);
      checkOutput("zero_stall", last_stall_f, 1'b0);
      checkOutput("zero_loaded", {valid_e_o, rd_e_o}, {1'b1, 5'd4});

      // JAL writes a register but is not a load
      applyStimulus(0, 0, 1, C_JAL, 32'd0, 32'd0, 5'd0, 5'd8, 5'd31);
      applyStimulus(0, 0, 1, C_ADD, 32'd1, 32'd2, 5'd8, 5'd8, 5'd5);
      checkOutput("jal_stall", last_stall_d, 1'b0);

      // Invalid instruction has its control zeroed
      applyStimulus(0, 0, 0, 10'h3ff, 32'd9, 32'd9, 5'd6, 5'd7, 5'd8);
      checkOutput("invalid_ctrl", {valid_e_o, ctrl_e_o}, 11'd0);

      // Flush beats load-use
      applyStimulus(0, 0, 1, C_LW, 32'd4, 32'd0, 5'd1, 5'd8, 5'd0);
      applyStimulus(0, 1, 1, C_ADD, 32'd5, 32'd6, 5'd8, 5'd3, 5'd2);
      checkOutput("flush_stall", {last_stall_f, last_stall_d}, 2'b00);
      checkOutput("flush_bubble", valid_e_o, 1'b0);
      checkOutput("flush_cnt", bubble_cnt_o, 16'd1);

      // Hold freezes everything, even with flush asserted
      applyStimulus(0, 0, 1, C_ADD, 32'h11, 32'h22, 5'd3, 5'd4, 5'd5);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 1, C_LW, 32'h100 + i, 32'h200 + i, 5'd9, 5'd10 + 5'(i), 5'd11);
         checkOutput("hold_rd1", rd1_e_o, 32'h11);
         checkOutput("hold_valid", valid_e_o, 1'b1);
      end
      applyStimulus(0, 1, 1, C_LW, 32'h300, 32'h400, 5'd9, 5'd12, 5'd11);
      checkOutput("hold_release_bubble", {valid_e_o, rd1_e_o}, 33'd0);

      // Five load-use bubbles: the 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, C_LW, 32'd50 + i, 32'd0, 5'd1, 5'd8, 5'd0);
         applyStimulus(0, 0, 1, C_ADD, 32'd60, 32'd61, 5'd2, 5'd8, 5'd3);
         if (i == 2) checkOutput("sat_cnt_third", s_cnt, 2'd3);
      end
      checkOutput("sat_cnt_fifth", s_cnt, 2'd3);
      checkOutput("cnt16_after_six", bubble_cnt_o, 16'd6);

      // Reset mid-stream with a load in EX and a hazard pending
      applyStimulus(0, 0, 1, C_LW, 32'd70, 32'd0, 5'd1, 5'd8, 5'd0);
      reset = 1'b1;
      applyStimulus(0, 0, 1, C_ADD, 32'd71, 32'd72, 5'd8, 5'd8, 5'd9);
      reset = 1'b0;
      checkOutput("mid_reset_fields", {valid_e_o, ctrl_e_o, rd1_e_o, rs_e_o}, 48'd0);
      checkOutput("mid_reset_cnt", bubble_cnt_o, 16'd0);
      checkOutput("mid_reset_sat_cnt", s_cnt, 2'd0);

      applyStimulus(0, 0, 0, 10'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
